tm_sr_dpr_sched: RTL and testbench

//   Sequencer in front of the TM/SR/DPR master message generator. Latches single-cycle

---
 rtl/tm_sr_dpr_sched_pkg.sv | 10 +
 rtl/tm_sr_dpr_sched_if.sv | 9 +
 rtl/tm_sr_dpr_sched_prio_arb3.sv | 7 +
 rtl/tm_sr_dpr_sched.sv | 84 ++++++++
 tb/tb_tm_sr_dpr_sched.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/tm_sr_dpr_sched_pkg.sv
// tm_sr_dpr_sched_pkg: shared grant bit indices, FSM states and default timing for the scheduler
package tm_sr_dpr_sched_pkg;
    localparam int TX_TM = 0;
    localparam int TX_SR = 1;
    localparam int TX_DPR = 2;
    localparam int GAP_DEF = 4;
    localparam int TIMEOUT_DEF = 1024;
    localparam int CNT_W_DEF = 11;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
endpackage

// File: rtl/tm_sr_dpr_sched_if.sv
// tm_sr_dpr_sched_if: request/grant bundle between the message sources and the scheduler
interface tm_sr_dpr_sched_if;
    logic en, tm_req, sr_req, dpr_req, msg_end, busy, timeout;
    logic [2:0] tx_state, pending, ovr;
    modport master (output en, tm_req, sr_req, dpr_req, msg_end,
                    input tx_state, busy, pending, ovr, timeout);
    modport slave (input en, tm_req, sr_req, dpr_req, msg_end,
                   output tx_state, busy, pending, ovr, timeout);
endinterface

// File: rtl/tm_sr_dpr_sched_prio_arb3.sv
// tm_sr_dpr_sched_prio_arb3: combinational fixed-priority one-hot picker, bit 0 highest
module tm_sr_dpr_sched_prio_arb3 (
    input  logic [2:0] in,
    output logic [2:0] gnt
);
    assign gnt = {in[2] & ~|in[1:0], in[1] & ~in[0], in[0]};
endmodule

// File: rtl/tm_sr_dpr_sched.sv
// tm_sr_dpr_sched: grants one TM/SR/DPR message at a time with watchdog and forced idle gap
module tm_sr_dpr_sched
    import tm_sr_dpr_sched_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic clk,
    input logic rst_n,
    tm_sr_dpr_sched_if.slave bus
);
    localparam int GAP_N = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    state_t state, state_nx;
    logic [2:0] req, gnt, clr, tx_state, tx_nx, pending, pend_nx, ovr, ovr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic timeout, to_nx;
    assign req[TX_TM] = bus.tm_req;
    assign req[TX_SR] = bus.sr_req;
    assign req[TX_DPR] = bus.dpr_req;
    tm_sr_dpr_sched_prio_arb3 u_arb (.in(pending), .gnt(gnt));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            tx_state <= '0;
            pending <= '0;
            ovr <= '0;
            timeout <= 1'b0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            tx_state <= tx_nx;
            pending <= pend_nx;
            ovr <= ovr_nx;
            timeout <= to_nx;
            cnt <= cnt_nx;
        end
    always_comb begin
        state_nx = state;
        tx_nx = tx_state;
        cnt_nx = cnt;
        to_nx = 1'b0;
        clr = '0;
        case (state)
            S_IDLE:
                if (bus.en && |pending) begin
                    clr = gnt;
                    tx_nx = gnt;
                    cnt_nx = '0;
                    state_nx = S_SEND;
                end
            S_SEND: begin
                cnt_nx = cnt + 1'b1;
                // msg_end takes precedence over a watchdog expiry in the same clock
                if (bus.msg_end || cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    to_nx = ~bus.msg_end;
                    tx_nx = '0;
                    cnt_nx = '0;
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == CNT_W'(GAP_N - 1)) begin
                    cnt_nx = '0;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                tx_nx = '0;
                cnt_nx = '0;
                state_nx = S_IDLE;
            end
        endcase
        // a new strobe on the bit being granted re-pends without flagging overrun
        pend_nx = (pending & ~clr) | req;
        ovr_nx = req & pending & ~clr;
    end
    assign bus.tx_state = tx_state;
    assign bus.pending = pending;
    assign bus.ovr = ovr;
    assign bus.timeout = timeout;
    assign bus.busy = state != S_IDLE;
endmodule

// File: tb/tb_tm_sr_dpr_sched.sv
// tb_tm_sr_dpr_sched: directed stimulus with an event scoreboard for grants, ends, overruns and timeouts
module tb_tm_sr_dpr_sched;
    localparam int EV_GNT = 0;
    localparam int EV_END = 1;
    localparam int EV_OVR = 2;
    localparam int EV_TO = 3;
    typedef struct {int typ; int val; int cyc;} ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];
    logic [2:0] prev = '0;
    tm_sr_dpr_sched_if bus ();
    tm_sr_dpr_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic expect_ev(input int typ, input int val, input int cy);
        exp_q.push_back('{typ, val, cy});
    endtask
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", name, act, req, cyc);
        end
    endtask
    task automatic pulse(input logic [2:0] r);
        {bus.dpr_req, bus.sr_req, bus.tm_req} = r;
        tick();
        {bus.dpr_req, bus.sr_req, bus.tm_req} = 3'b000;
    endtask
    task automatic end_msg();
        bus.msg_end = 1'b1;
        tick();
        bus.msg_end = 1'b0;
    endtask
    task automatic chk_ev(input int typ, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event type %0d val %0d at cycle %0d, none expected", typ, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.typ != typ || e.val != val || e.cyc != cyc) begin
                errors++;
                $display("FAIL event got type %0d val %0d cycle %0d want type %0d val %0d cycle %0d",
                         typ, val, cyc, e.typ, e.val, e.cyc);
            end
        end
    endtask
    always @(negedge clk) begin
        if (bus.ovr != 3'b000) chk_ev(EV_OVR, int'(bus.ovr));
        if (bus.timeout) chk_ev(EV_TO, 1);
        if (bus.tx_state != prev && prev != 3'b000) chk_ev(EV_END, int'(prev));
        if (bus.tx_state != prev && bus.tx_state != 3'b000) chk_ev(EV_GNT, int'(bus.tx_state));
        prev = bus.tx_state;
    end
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int e;
        int p;
        bus.en = 1'b1;
        {bus.tm_req, bus.sr_req, bus.dpr_req, bus.msg_end} = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        chk("rst_tx", int'(bus.tx_state), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_ovr", int'(bus.ovr), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        // single TM message, gap timing
        tick(8);
        pulse(3'b001);
        p = cyc;
        expect_ev(EV_GNT, 1, p + 1);
        chk("t1_pending", int'(bus.pending), 1);
        chk("t1_tx_pre", int'(bus.tx_state), 0);
        tick();
        chk("t1_busy", int'(bus.busy), 1);
        chk("t1_pending_clr", int'(bus.pending), 0);
        tick(18);
        end_msg();
        e = cyc;
        expect_ev(EV_END, 1, e);
        tick(3);
        chk("t1_gap_tx", int'(bus.tx_state), 0);
        chk("t1_gap_busy", int'(bus.busy), 1);
        tick();
        chk("t1_idle_busy", int'(bus.busy), 0);
        chk("t1_idle_pending", int'(bus.pending), 0);
        // SR beats DPR, DPR follows after the gap
        pulse(3'b110);
        p = cyc;
        expect_ev(EV_GNT, 2, p + 1);
        tick(3);
        end_msg();
        e = cyc;
        expect_ev(EV_END, 2, e);
        expect_ev(EV_GNT, 4, e + 5);
        chk("t2_pending", int'(bus.pending), 4);
        tick(7);
        end_msg();
        expect_ev(EV_END, 4, cyc);
        tick(6);
        // DPR overrun while queued behind TM
        pulse(3'b001);
        p = cyc;
        expect_ev(EV_GNT, 1, p + 1);
        pulse(3'b100);
        expect_ev(EV_OVR, 4, cyc + 1);
        pulse(3'b100);
        chk("t3_pending", int'(bus.pending), 4);
        tick(2);
        end_msg();
        e = cyc;
        expect_ev(EV_END, 1, e);
        expect_ev(EV_GNT, 4, e + 5);
        tick(7);
        end_msg();
        expect_ev(EV_END, 4, cyc);
        tick(10);
        chk("t3_pending_end", int'(bus.pending), 0);
        // watchdog timeout on the 1024th SEND clock
        pulse(3'b001);
        p = cyc;
        expect_ev(EV_GNT, 1, p + 1);
        expect_ev(EV_TO, 1, p + 1025);
        expect_ev(EV_END, 1, p + 1025);
        tick(1024);
        chk("t4_tx_held", int'(bus.tx_state), 1);
        tick();
        chk("t4_tx_drop", int'(bus.tx_state), 0);
        tick(3);
        chk("t4_gap_busy", int'(bus.busy), 1);
        tick();
        chk("t4_idle_busy", int'(bus.busy), 0);
        // enable gating
        bus.en = 1'b0;
        pulse(3'b001);
        tick(3);
        chk("t5_pending", int'(bus.pending), 1);
        chk("t5_tx_idle", int'(bus.tx_state), 0);
        chk("t5_busy_idle", int'(bus.busy), 0);
        bus.en = 1'b1;
        expect_ev(EV_GNT, 1, cyc + 1);
        tick();
        chk("t5_tx_grant", int'(bus.tx_state), 1);
        bus.en = 1'b0;
        tick(3);
        chk("t5_tx_hold", int'(bus.tx_state), 1);
        end_msg();
        expect_ev(EV_END, 1, cyc);
        tick(4);
        chk("t5_done_busy", int'(bus.busy), 0);
        pulse(3'b010);
        tick(2);
        chk("t5_sr_pending", int'(bus.pending), 2);
        bus.en = 1'b1;
        expect_ev(EV_GNT, 2, cyc + 1);
        tick();
        // async reset mid-SEND with two requests queued
        pulse(3'b110);
        chk("t6_pending", int'(bus.pending), 6);
        expect_ev(EV_END, 2, cyc);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_tx", int'(bus.tx_state), 0);
        chk("t6_rst_pending", int'(bus.pending), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        tick();
        rst_n = 1'b1;
        tick(10);
        chk("t6_post_tx", int'(bus.tx_state), 0);
        chk("t6_post_busy", int'(bus.busy), 0);
        pulse(3'b001);
        expect_ev(EV_GNT, 1, cyc + 1);
        tick(3);
        end_msg();
        expect_ev(EV_END, 1, cyc);
        tick(8);
        while (exp_q.size() != 0) begin
            ev_t m;
            m = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event type %0d val %0d cycle %0d never seen", m.typ, m.val, m.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
